// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with valid/ready fetch port and line-fill miss handler.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache_dm #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned WORDS   = 4,
    parameter int unsigned LINES   = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       req_valid_i,
    input  logic [ADDR_W-1:0]          req_addr_i,
    output logic                       req_ready_o,
    output logic                       resp_valid_o,
    output logic [INSTR_W-1:0]         resp_instr_o,
    input  logic                       flush_i,
    output logic                       mem_req_valid_o,
    output logic [ADDR_W-1:0]          mem_req_addr_o,
    input  logic                       mem_req_ready_i,
    input  logic                       mem_resp_valid_i,
    input  logic [INSTR_W*WORDS-1:0]   mem_resp_data_i
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]                hit_count_o,
    output logic [31:0]                miss_count_o
`endif
);

    localparam int unsigned LINE_W = INSTR_W * WORDS;
    localparam int unsigned BYTE_B = $clog2(INSTR_W / 8);
    localparam int unsigned OFF_B  = $clog2(WORDS);
    localparam int unsigned IDX_B  = $clog2(LINES);
    localparam int unsigned TAG_B  = ADDR_W - BYTE_B - OFF_B - IDX_B;
    localparam int unsigned LINE_LSB = BYTE_B + OFF_B;

    typedef enum logic [1:0] {StIdle, StMissReq, StMissWait} state_e;

    state_e               state_q;
    logic [LINES-1:0]     valid_q;
    logic [TAG_B-1:0]     tag_q  [LINES];
    logic [LINE_W-1:0]    data_q [LINES];
    logic                 resp_valid_q;
    logic [INSTR_W-1:0]   resp_instr_q;
    logic                 mem_req_valid_q;
    logic [ADDR_W-1:0]    mem_req_addr_q;
    logic [OFF_B-1:0]     miss_off_q;
    logic                 flush_pend_q;

    logic [OFF_B-1:0]     req_off;
    logic [IDX_B-1:0]     req_idx;
    logic [TAG_B-1:0]     req_tag;
    logic [IDX_B-1:0]     fill_idx;
    logic [TAG_B-1:0]     fill_tag;
    logic [ADDR_W-1:0]    line_addr;
    logic [INSTR_W-1:0]   hit_word;
    logic [INSTR_W-1:0]   fill_word;
    logic                 hit;
    logic                 accept;
    logic                 fill;
    logic                 unused_addr;

    always_comb begin
        req_off   = req_addr_i[BYTE_B +: OFF_B];
        req_idx   = req_addr_i[LINE_LSB +: IDX_B];
        req_tag   = req_addr_i[ADDR_W-1 -: TAG_B];
        line_addr = {req_addr_i[ADDR_W-1:LINE_LSB], {LINE_LSB{1'b0}}};
        fill_idx  = mem_req_addr_q[LINE_LSB +: IDX_B];
        fill_tag  = mem_req_addr_q[ADDR_W-1 -: TAG_B];
        hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
        hit_word  = data_q[req_idx][32'(req_off) * INSTR_W +: INSTR_W];
        fill_word = mem_resp_data_i[32'(miss_off_q) * INSTR_W +: INSTR_W];
    end

    assign req_ready_o     = (state_q == StIdle) && !flush_i;
    assign accept          = req_valid_i && req_ready_o;
    assign fill            = (state_q == StMissWait) && mem_resp_valid_i;
    assign resp_valid_o    = resp_valid_q;
    assign resp_instr_o    = resp_instr_q;
    assign mem_req_valid_o = mem_req_valid_q;
    assign mem_req_addr_o  = mem_req_addr_q;
    // Byte-select bits below the instruction boundary carry no information.
    assign unused_addr     = ^req_addr_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q         <= StIdle;
            valid_q         <= '0;
            resp_valid_q    <= 1'b0;
            resp_instr_q    <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            miss_off_q      <= '0;
            flush_pend_q    <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (flush_i) begin
                        valid_q <= '0;
                    end else if (accept) begin
                        if (hit) begin
                            resp_valid_q <= 1'b1;
                            resp_instr_q <= hit_word;
                        end else begin
                            mem_req_valid_q <= 1'b1;
                            mem_req_addr_q  <= line_addr;
                            miss_off_q      <= req_off;
                            state_q         <= StMissReq;
                        end
                    end
                end
                StMissReq: begin
                    if (flush_i) flush_pend_q <= 1'b1;
                    if (mem_req_ready_i) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= StMissWait;
                    end
                end
                StMissWait: begin
                    if (fill) begin
                        resp_valid_q <= 1'b1;
                        resp_instr_q <= fill_word;
                        flush_pend_q <= 1'b0;
                        state_q      <= StIdle;
                        // A flush seen during the miss also drops the line just filled.
                        if (flush_pend_q || flush_i) valid_q <= '0;
                        else valid_q[fill_idx] <= 1'b1;
                    end else if (flush_i) begin
                        flush_pend_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i && fill) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= mem_resp_data_i;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hit_count_o  <= '0;
            miss_count_o <= '0;
        end else if (accept) begin
            if (hit && hit_count_o != 32'hFFFF_FFFF) hit_count_o <= hit_count_o + 32'd1;
            if (!hit && miss_count_o != 32'hFFFF_FFFF) miss_count_o <= miss_count_o + 32'd1;
        end
    end
`endif

endmodule

// File: doc/icache_dm.md
# icache_dm

Parametrised direct-mapped instruction cache with an integrated miss-handling state machine, sitting between the fetch stage and the instruction memory of the pipelined MIPS core. Generalises the fixed 8-line × 64-bit cache to configurable address width, instruction width, line size and line count. Adds a valid/ready request handshake, an explicit line-fill protocol toward memory, whole-cache flush and synchronous reset. Hits return one instruction per cycle back-to-back; a miss stalls the requester until the line is filled.

## Interface
- ADDR_W, 16, byte-address width
- INSTR_W, 16, instruction width in bits (multiple of 8, power of two)
- WORDS, 4, instructions per line (power of two, ≥2)
- LINES, 8, number of lines (power of two, ≥2)
- Derived: LINE_W = INSTR_W·WORDS; BYTE_B = log2(INSTR_W/8); OFF_B = log2(WORDS); IDX_B = log2(LINES); TAG_B = ADDR_W−BYTE_B−OFF_B−IDX_B
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  fetch request
- req_addr  in  ADDR_W  byte address; low BYTE_B bits ignored
- req_ready  out  1  cache can accept (combinational: state==IDLE && !flush)
- resp_valid  out  1  one-cycle pulse, instruction valid; no backpressure
- resp_instr  out  INSTR_W  returned instruction
- flush  in  1  invalidate all lines
- mem_req_valid  out  1  line-fill request
- mem_req_addr  out  ADDR_W  line-aligned address (low BYTE_B+OFF_B bits zero)
- mem_req_ready  in  1  memory accepts request
- mem_resp_valid  in  1  fill data valid, one-cycle pulse
- mem_resp_data  in  LINE_W  line; word w at bits [w·INSTR_W +: INSTR_W]

## Operation
- Address split: offset = addr[BYTE_B +: OFF_B], index = addr[BYTE_B+OFF_B +: IDX_B], tag = top TAG_B bits.
- Per line: valid bit, tag, LINE_W data.
- States: IDLE, MISS_REQ, MISS_WAIT.
- IDLE, accept (req_valid && req_ready): array read combinationally. Hit (valid && tag match): next edge resp_valid=1, resp_instr=word[offset], stay IDLE. Miss: latch addr, mem_req_valid=1, go MISS_REQ.
- MISS_REQ: hold mem_req_valid and mem_req_addr stable until sampled mem_req_ready=1, then drop mem_req_valid, go MISS_WAIT.
- MISS_WAIT: on mem_resp_valid, write data/tag, set valid; same edge register resp_valid=1, resp_instr=mem_resp_data word[latched offset]; go IDLE.
- mem_resp_valid outside MISS_WAIT is ignored.
- flush in IDLE: all valid bits cleared at that edge; any concurrent req is not accepted (req_ready=0).
- flush outside IDLE: latched as pending; at fill edge the requester still gets its instruction, but all valid bits are cleared (including the filled line) and pending clears.
- resp_valid is 0 in every cycle not listed above.

## Timing
- Reset: state IDLE, all valid bits 0, resp_valid=0, resp_instr=0, mem_req_valid=0, mem_req_addr=0, flush pending=0. Data/tag arrays not reset.
- Hit latency: 1 cycle (accept edge N → resp_valid high N+1); throughput 1/cycle.
- Miss latency: 1 + request-wait cycles + response-wait cycles + 1; req_ready low from cycle after miss accept until back in IDLE.
- Reset mid-miss abandons the fill; mem_req_valid low the cycle after reset; a late mem_resp_valid is ignored.
- Index wrap: addresses differing only in tag evict each other; no stale-hit permitted.

## Configuration
- ICACHE_STATS_EN defined: extra outputs hit_count and miss_count (32-bit each, reset 0, saturate at 2^32−1), incremented on the accept edge of a hit or miss respectively.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- After reset, req 0x0040 → miss, mem_req_addr=0x0040; return line 0x4444_3333_2222_1111 → resp_instr=0x1111; then 0x0042,0x0044,0x0046 back-to-back → 0x2222,0x3333,0x4444 on consecutive cycles, no mem_req.
- Conflict: fill 0x0040, then 0x0240 (same index, tag differs) → miss and refill; 0x0040 again → miss.
- mem_req_ready held low 5 cycles → mem_req_valid/addr stable throughout, req_ready=0, no resp_valid.
- Flush in IDLE after fills → next access to 0x0040 misses; flush during MISS_WAIT → instruction returned, following request to same address misses.
- Reset asserted in MISS_WAIT, then stray mem_resp_valid → no resp_valid, no line valid; with ICACHE_STATS_EN, 3 hits + 2 misses → hit_count=3, miss_count=2.
